// File: rtl/mem_stage_if.sv
// Data-memory request/response bus between the memory stage and the data memory.
// Latency: none (wires only); the master holds req/we/addr/be/wdata stable until gnt.
// Backpressure: gnt stalls the request phase; rvalid marks the load response (never before the cycle after gnt).
// Ports: req/we/addr/be/wdata driven by master; gnt/rvalid/rdata driven by slave.
interface mem_stage_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (
        output req, we, addr, be, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, be, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/mem_stage.sv
// Memory-access stage: runs loads/stores on the data-memory bus, passes other instructions to WB.
// Latency: 1 cycle for non-memory/misaligned, 2+ for stores (req..gnt), 3+ for loads (req..gnt..rvalid).
// Backpressure: in_ready is low while an access is outstanding (REQ/RSP); the dmem bus stalls via gnt.
// Ports: clk/rst (sync active-high), in_valid/in_data/in_ready from EX, dmem (master modport),
//        out_* registered bundle to WB with a one-cycle out_valid pulse per instruction.
package mem_stage_pkg;
    localparam logic [3:0] LSU_NONE = 4'd0;
    localparam logic [3:0] LSU_LB   = 4'd1;
    localparam logic [3:0] LSU_LH   = 4'd2;
    localparam logic [3:0] LSU_LW   = 4'd3;
    localparam logic [3:0] LSU_LBU  = 4'd4;
    localparam logic [3:0] LSU_LHU  = 4'd5;
    localparam logic [3:0] LSU_SB   = 4'd6;
    localparam logic [3:0] LSU_SH   = 4'd7;
    localparam logic [3:0] LSU_SW   = 4'd8;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] opr_b;
        logic [31:0] opr_res;
        logic [31:0] pc4;
        logic [3:0]  lsuop;
        logic        rf_en;
        logic        dm_en;
        logic [1:0]  wb_sel;
    } ex_stage_out_t;
endpackage

module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  ex_stage_out_t     in_data,
    output logic              in_ready,
    mem_stage_if.master       dmem,
    output logic              out_valid,
    output logic [4:0]        out_rd,
    output logic              out_rf_en,
    output logic [1:0]        out_wb_sel,
    output logic [XLEN-1:0]   out_opr_res,
    output logic [XLEN-1:0]   out_pc4,
    output logic [XLEN-1:0]   out_ldata,
    output logic              out_misaligned
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_RSP  = 2'd2;

    function automatic logic is_load_op(input logic [3:0] op);
        return (op == LSU_LB) || (op == LSU_LH) || (op == LSU_LW) ||
               (op == LSU_LBU) || (op == LSU_LHU);
    endfunction

    function automatic logic is_store_op(input logic [3:0] op);
        return (op == LSU_SB) || (op == LSU_SH) || (op == LSU_SW);
    endfunction

    logic [1:0]  state_q, state_d;
    // Latched request and instruction context for the outstanding access.
    logic [4:0]  rd_q, rd_d;
    logic [31:0] opr_res_q, opr_res_d;
    logic [31:0] pc4_q, pc4_d;
    logic [3:0]  lsuop_q, lsuop_d;
    logic        rf_en_q, rf_en_d;
    logic [1:0]  wb_sel_q, wb_sel_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    // WB output register.
    logic        out_valid_q, out_valid_d;
    logic [4:0]  out_rd_q, out_rd_d;
    logic        out_rf_en_q, out_rf_en_d;
    logic [1:0]  out_wb_sel_q, out_wb_sel_d;
    logic [31:0] out_opr_res_q, out_opr_res_d;
    logic [31:0] out_pc4_q, out_pc4_d;
    logic [31:0] out_ldata_q, out_ldata_d;
    logic        out_misaligned_q, out_misaligned_d;

    // Decode of the incoming instruction.
    logic        in_mem_op;
    logic        in_byte, in_half;
    logic [1:0]  in_off;
    logic        in_misaligned;
    logic [3:0]  in_be;
    logic [31:0] in_wdata;
    // Load extraction from the response word.
    logic [31:0] rd_shifted;
    logic [31:0] ldata_ext;

    always_comb begin
        in_off    = in_data.opr_res[1:0];
        in_byte   = (in_data.lsuop == LSU_LB) || (in_data.lsuop == LSU_LBU) ||
                    (in_data.lsuop == LSU_SB);
        in_half   = (in_data.lsuop == LSU_LH) || (in_data.lsuop == LSU_LHU) ||
                    (in_data.lsuop == LSU_SH);
        // dm_en with a lsuop that is neither load nor store behaves as an ALU op.
        in_mem_op = in_data.dm_en && (is_load_op(in_data.lsuop) || is_store_op(in_data.lsuop));
        in_misaligned = (in_half && in_off[0]) || (!in_byte && !in_half && (in_off != 2'b00));
        if (in_byte) begin
            in_be    = 4'b0001 << in_off;
            in_wdata = {4{in_data.opr_b[7:0]}};
        end else if (in_half) begin
            in_be    = 4'b0011 << in_off;
            in_wdata = {2{in_data.opr_b[15:0]}};
        end else begin
            in_be    = 4'b1111;
            in_wdata = in_data.opr_b;
        end
    end

    always_comb begin
        rd_shifted = dmem.rdata >> {opr_res_q[1:0], 3'b000};
        case (lsuop_q)
            LSU_LB:  ldata_ext = {{24{rd_shifted[7]}}, rd_shifted[7:0]};
            LSU_LBU: ldata_ext = {24'h0, rd_shifted[7:0]};
            LSU_LH:  ldata_ext = {{16{rd_shifted[15]}}, rd_shifted[15:0]};
            LSU_LHU: ldata_ext = {16'h0, rd_shifted[15:0]};
            default: ldata_ext = dmem.rdata;
        endcase
    end

    always_comb begin
        state_d          = state_q;
        rd_d             = rd_q;
        opr_res_d        = opr_res_q;
        pc4_d            = pc4_q;
        lsuop_d          = lsuop_q;
        rf_en_d          = rf_en_q;
        wb_sel_d         = wb_sel_q;
        be_d             = be_q;
        wdata_d          = wdata_q;
        out_valid_d      = 1'b0;
        out_rd_d         = out_rd_q;
        out_rf_en_d      = out_rf_en_q;
        out_wb_sel_d     = out_wb_sel_q;
        out_opr_res_d    = out_opr_res_q;
        out_pc4_d        = out_pc4_q;
        out_ldata_d      = out_ldata_q;
        out_misaligned_d = out_misaligned_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (!in_mem_op || in_misaligned) begin
                        // Completes immediately; a misaligned access never reaches the bus.
                        out_valid_d      = 1'b1;
                        out_rd_d         = in_data.rd;
                        out_rf_en_d      = in_data.rf_en && !in_mem_op;
                        out_wb_sel_d     = in_data.wb_sel;
                        out_opr_res_d    = in_data.opr_res;
                        out_pc4_d        = in_data.pc4;
                        out_ldata_d      = 32'h0;
                        out_misaligned_d = in_mem_op;
                    end else begin
                        rd_d      = in_data.rd;
                        opr_res_d = in_data.opr_res;
                        pc4_d     = in_data.pc4;
                        lsuop_d   = in_data.lsuop;
                        rf_en_d   = in_data.rf_en;
                        wb_sel_d  = in_data.wb_sel;
                        be_d      = in_be;
                        wdata_d   = in_wdata;
                        state_d   = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (dmem.gnt) begin
                    if (is_store_op(lsuop_q)) begin
                        out_valid_d      = 1'b1;
                        out_rd_d         = rd_q;
                        out_rf_en_d      = rf_en_q;
                        out_wb_sel_d     = wb_sel_q;
                        out_opr_res_d    = opr_res_q;
                        out_pc4_d        = pc4_q;
                        out_ldata_d      = 32'h0;
                        out_misaligned_d = 1'b0;
                        state_d          = S_IDLE;
                    end else begin
                        state_d = S_RSP;
                    end
                end
            end
            S_RSP: begin
                if (dmem.rvalid) begin
                    out_valid_d      = 1'b1;
                    out_rd_d         = rd_q;
                    out_rf_en_d      = rf_en_q;
                    out_wb_sel_d     = wb_sel_q;
                    out_opr_res_d    = opr_res_q;
                    out_pc4_d        = pc4_q;
                    out_ldata_d      = ldata_ext;
                    out_misaligned_d = 1'b0;
                    state_d          = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= S_IDLE;
            rd_q             <= '0;
            opr_res_q        <= '0;
            pc4_q            <= '0;
            lsuop_q          <= '0;
            rf_en_q          <= 1'b0;
            wb_sel_q         <= '0;
            be_q             <= '0;
            wdata_q          <= '0;
            out_valid_q      <= 1'b0;
            out_rd_q         <= '0;
            out_rf_en_q      <= 1'b0;
            out_wb_sel_q     <= '0;
            out_opr_res_q    <= '0;
            out_pc4_q        <= '0;
            out_ldata_q      <= '0;
            out_misaligned_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            rd_q             <= rd_d;
            opr_res_q        <= opr_res_d;
            pc4_q            <= pc4_d;
            lsuop_q          <= lsuop_d;
            rf_en_q          <= rf_en_d;
            wb_sel_q         <= wb_sel_d;
            be_q             <= be_d;
            wdata_q          <= wdata_d;
            out_valid_q      <= out_valid_d;
            out_rd_q         <= out_rd_d;
            out_rf_en_q      <= out_rf_en_d;
            out_wb_sel_q     <= out_wb_sel_d;
            out_opr_res_q    <= out_opr_res_d;
            out_pc4_q        <= out_pc4_d;
            out_ldata_q      <= out_ldata_d;
            out_misaligned_q <= out_misaligned_d;
        end
    end

    assign in_ready       = (state_q == S_IDLE);
    assign dmem.req       = (state_q == S_REQ);
    assign dmem.we        = (state_q == S_REQ) && is_store_op(lsuop_q);
    assign dmem.addr      = {opr_res_q[31:2], 2'b00};
    assign dmem.be        = be_q;
    assign dmem.wdata     = wdata_q;

    assign out_valid      = out_valid_q;
    assign out_rd         = out_rd_q;
    assign out_rf_en      = out_rf_en_q;
    assign out_wb_sel     = out_wb_sel_q;
    assign out_opr_res    = out_opr_res_q;
    assign out_pc4        = out_pc4_q;
    assign out_ldata      = out_ldata_q;
    assign out_misaligned = out_misaligned_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU pass-through, stores with gnt stalls, loads with extension,
// misalignment, reset during a response wait, and back-to-back hold of a following instruction.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    ex_stage_out_t in_data;
    logic          in_ready;
    logic          out_valid;
    logic [4:0]    out_rd;
    logic          out_rf_en;
    logic [1:0]    out_wb_sel;
    logic [31:0]   out_opr_res;
    logic [31:0]   out_pc4;
    logic [31:0]   out_ldata;
    logic          out_misaligned;

    mem_stage_if dm ();

    mem_stage #(.XLEN(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .in_ready       (in_ready),
        .dmem           (dm),
        .out_valid      (out_valid),
        .out_rd         (out_rd),
        .out_rf_en      (out_rf_en),
        .out_wb_sel     (out_wb_sel),
        .out_opr_res    (out_opr_res),
        .out_pc4        (out_pc4),
        .out_ldata      (out_ldata),
        .out_misaligned (out_misaligned)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int pulses = 0;

    always @(negedge clk) if (out_valid === 1'b1) pulses++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [3:0] op, input logic dm_en, input logic [4:0] rd,
                             input logic [31:0] res, input logic [31:0] b, input logic rf_en);
        in_data.rd      = rd;
        in_data.opr_b   = b;
        in_data.opr_res = res;
        in_data.pc4     = 32'h0000_0104;
        in_data.lsuop   = op;
        in_data.rf_en   = rf_en;
        in_data.dm_en   = dm_en;
        in_data.wb_sel  = 2'd1;
    endtask

    // Load with gnt immediately and rvalid two cycles after gnt.
    task automatic do_load(input string tag, input logic [3:0] op, input logic [31:0] addr,
                           input logic [31:0] rdata, input logic [3:0] exp_be,
                           input logic [31:0] exp_ldata);
        set_instr(op, 1'b1, 5'd9, addr, 32'h0, 1'b1);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk({tag, "_req"}, {31'h0, dm.req}, 32'd1);
        chk({tag, "_we"},  {31'h0, dm.we}, 32'd0);
        chk({tag, "_be"},  {28'h0, dm.be}, {28'h0, exp_be});
        chk({tag, "_addr"}, dm.addr, {addr[31:2], 2'b00});
        dm.gnt = 1'b1;
        tick();
        dm.gnt = 1'b0;
        tick();
        chk({tag, "_rsp_rdy"}, {31'h0, in_ready}, 32'd0);
        dm.rvalid = 1'b1;
        dm.rdata  = rdata;
        tick();
        dm.rvalid = 1'b0;
        dm.rdata  = 32'h0;
        chk({tag, "_vld"},   {31'h0, out_valid}, 32'd1);
        chk({tag, "_ldata"}, out_ldata, exp_ldata);
        chk({tag, "_rd"},    {27'h0, out_rd}, 32'd9);
        tick();
        chk({tag, "_vld_off"}, {31'h0, out_valid}, 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        dm.gnt    = 1'b0;
        dm.rvalid = 1'b0;
        dm.rdata  = 32'h0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk("rst_in_ready", {31'h0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'h0, out_valid}, 32'd0);
        chk("rst_req", {31'h0, dm.req}, 32'd0);
        chk("rst_opr_res", out_opr_res, 32'h0);
        chk("rst_ldata", out_ldata, 32'h0);

        // ALU pass-through
        set_instr(LSU_NONE, 1'b0, 5'd5, 32'h0000_1234, 32'h0, 1'b1);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("alu_vld", {31'h0, out_valid}, 32'd1);
        chk("alu_rd", {27'h0, out_rd}, 32'd5);
        chk("alu_res", out_opr_res, 32'h0000_1234);
        chk("alu_ldata", out_ldata, 32'h0);
        chk("alu_rf_en", {31'h0, out_rf_en}, 32'd1);
        chk("alu_pc4", out_pc4, 32'h0000_0104);
        chk("alu_req", {31'h0, dm.req}, 32'd0);
        tick();
        chk("alu_vld_off", {31'h0, out_valid}, 32'd0);

        // dm_en with a non-memory lsuop behaves as ALU
        set_instr(4'd15, 1'b1, 5'd6, 32'h0000_2003, 32'h0, 1'b1);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("nop_vld", {31'h0, out_valid}, 32'd1);
        chk("nop_mis", {31'h0, out_misaligned}, 32'd0);
        chk("nop_req", {31'h0, dm.req}, 32'd0);
        tick();

        // SB with gnt held low for two cycles
        set_instr(LSU_SB, 1'b1, 5'd0, 32'h0000_1003, 32'h0000_00AB, 1'b0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("sb_req", {31'h0, dm.req}, 32'd1);
            chk("sb_we", {31'h0, dm.we}, 32'd1);
            chk("sb_be", {28'h0, dm.be}, 32'h8);
            chk("sb_wdata", dm.wdata, 32'hABAB_ABAB);
            chk("sb_addr", dm.addr, 32'h0000_1000);
            chk("sb_in_ready", {31'h0, in_ready}, 32'd0);
            chk("sb_vld_wait", {31'h0, out_valid}, 32'd0);
            if (i == 2) dm.gnt = 1'b1;
            else tick();
        end
        tick();
        dm.gnt = 1'b0;
        chk("sb_vld", {31'h0, out_valid}, 32'd1);
        chk("sb_ldata", out_ldata, 32'h0);
        chk("sb_req_off", {31'h0, dm.req}, 32'd0);
        chk("sb_in_ready_back", {31'h0, in_ready}, 32'd1);
        tick();

        // SH at upper halfword, immediate gnt
        set_instr(LSU_SH, 1'b1, 5'd0, 32'h0000_1002, 32'h1234_ABCD, 1'b0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("sh_be", {28'h0, dm.be}, 32'hC);
        chk("sh_wdata", dm.wdata, 32'hABCD_ABCD);
        dm.gnt = 1'b1;
        tick();
        dm.gnt = 1'b0;
        chk("sh_vld", {31'h0, out_valid}, 32'd1);
        tick();

        // Spurious rvalid in IDLE is ignored
        dm.rvalid = 1'b1;
        tick();
        dm.rvalid = 1'b0;
        chk("idle_rvalid_ign", {31'h0, out_valid}, 32'd0);

        // Loads with extension
        do_load("lb",  LSU_LB,  32'h0000_2002, 32'h0080_FF00, 4'b0100, 32'hFFFF_FF80);
        do_load("lbu", LSU_LBU, 32'h0000_2002, 32'h0080_FF00, 4'b0100, 32'h0000_0080);
        do_load("lh",  LSU_LH,  32'h0000_2002, 32'h8001_0000, 4'b1100, 32'hFFFF_8001);
        do_load("lhu", LSU_LHU, 32'h0000_2002, 32'h8001_0000, 4'b1100, 32'h0000_8001);
        do_load("lw",  LSU_LW,  32'h0000_2000, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF);

        // Misaligned LW and LH
        set_instr(LSU_LW, 1'b1, 5'd4, 32'h0000_2001, 32'h0, 1'b1);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("lw_mis_req", {31'h0, dm.req}, 32'd0);
        chk("lw_mis_vld", {31'h0, out_valid}, 32'd1);
        chk("lw_mis_flag", {31'h0, out_misaligned}, 32'd1);
        chk("lw_mis_rf_en", {31'h0, out_rf_en}, 32'd0);
        chk("lw_mis_rdy", {31'h0, in_ready}, 32'd1);
        set_instr(LSU_LH, 1'b1, 5'd4, 32'h0000_2003, 32'h0, 1'b1);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("lh_mis_req", {31'h0, dm.req}, 32'd0);
        chk("lh_mis_flag", {31'h0, out_misaligned}, 32'd1);
        tick();

        // Reset while waiting in RSP, then a late rvalid
        set_instr(LSU_LW, 1'b1, 5'd8, 32'h0000_3000, 32'h0, 1'b1);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        dm.gnt = 1'b1;
        tick();
        dm.gnt = 1'b0;
        chk("rsp_in_ready", {31'h0, in_ready}, 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_rdy", {31'h0, in_ready}, 32'd1);
        chk("mid_rst_req", {31'h0, dm.req}, 32'd0);
        dm.rvalid = 1'b1;
        dm.rdata  = 32'h5555_AAAA;
        tick();
        dm.rvalid = 1'b0;
        chk("mid_rst_vld", {31'h0, out_valid}, 32'd0);
        chk("mid_rst_ldata", out_ldata, 32'h0);
        tick();

        // Back-to-back LW then ADD held continuously
        pulses = 0;
        set_instr(LSU_LW, 1'b1, 5'd3, 32'h0000_4000, 32'h0, 1'b1);
        in_valid = 1'b1;
        tick();
        set_instr(LSU_NONE, 1'b0, 5'd7, 32'h0000_0055, 32'h0, 1'b1);
        chk("b2b_hold_req", {31'h0, in_ready}, 32'd0);
        dm.gnt = 1'b1;
        tick();
        dm.gnt = 1'b0;
        chk("b2b_hold_rsp", {31'h0, in_ready}, 32'd0);
        chk("b2b_no_early_vld", {31'h0, out_valid}, 32'd0);
        dm.rvalid = 1'b1;
        dm.rdata  = 32'h1111_2222;
        tick();
        dm.rvalid = 1'b0;
        chk("b2b_lw_vld", {31'h0, out_valid}, 32'd1);
        chk("b2b_lw_rd", {27'h0, out_rd}, 32'd3);
        chk("b2b_lw_ldata", out_ldata, 32'h1111_2222);
        tick();
        in_valid = 1'b0;
        chk("b2b_add_vld", {31'h0, out_valid}, 32'd1);
        chk("b2b_add_rd", {27'h0, out_rd}, 32'd7);
        chk("b2b_add_res", out_opr_res, 32'h0000_0055);
        chk("b2b_add_ldata", out_ldata, 32'h0);
        tick();
        tick();
        chk("b2b_pulses", pulses, 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage, directly downstream of the EX stage; consumes the ex_stage_out_t bundle.
- Runs loads and stores over a req/gnt/rvalid data-memory bus: byte enables, store-data lane steering, load extraction and sign/zero extension.
- Non-memory instructions pass through with one register stage.
- Output register feeds WB; in_ready back-pressures EX while an access is outstanding.

Parameters:
- XLEN, 32, data/address width (only 32 supported)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  EX bundle valid
- in_data  in  ex_stage_out_t  rd, opr_b (store data), opr_res (address / ALU result), pc4, lsuop, rf_en, dm_en, wb_sel
- in_ready  out  1  stage accepts in_data this cycle
- dmem_req  out  1  memory request valid
- dmem_we  out  1  1 = store
- dmem_addr  out  32  word-aligned address (opr_res[31:2], 2'b00)
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-steered store data
- dmem_gnt  in  1  request accepted
- dmem_rvalid  in  1  load response valid
- dmem_rdata  in  32  load response word
- out_valid  out  1  WB bundle valid (one-cycle pulse per instruction)
- out_rd  out  5  destination register
- out_rf_en  out  1  register write enable
- out_wb_sel  out  2  WB mux select (passed through)
- out_opr_res  out  32  ALU result
- out_pc4  out  32  pc+4
- out_ldata  out  32  extended load data (0 for non-loads)
- out_misaligned  out  1  access was misaligned and suppressed

Behaviour:
- Reset: state=IDLE; all out_* = 0; dmem_req=0; latched request registers = 0.
- FSM states: IDLE, REQ, RSP.
- in_ready = (state==IDLE). An instruction is accepted when in_valid & in_ready.
- IDLE, accepted, dm_en=0: out_* registered from in_data; out_ldata=0; out_valid=1 next cycle (latency 1); stay IDLE.
- IDLE, accepted, dm_en=1, misaligned: no request. out_valid=1 next cycle with out_misaligned=1 and out_rf_en=0; stay IDLE.
  - Misaligned means: halfword op with addr[0]=1, or word op with addr[1:0]!=0.
- IDLE, accepted, dm_en=1, aligned: latch rd, addr, be, wdata, lsuop, rf_en, wb_sel, pc4, opr_res; go to REQ.
- REQ: dmem_req=1. dmem_* come from latched registers and stay stable until gnt.
  - gnt & store: go to IDLE; out_valid=1 next cycle, out_ldata=0 (latency 2 with immediate gnt).
  - gnt & load: go to RSP.
- RSP: dmem_req=0.
  - On rvalid: extract and extend; out_valid=1 next cycle; go to IDLE (load latency 3 minimum).
- dmem_rvalid is ignored outside RSP. dmem_gnt is ignored outside REQ. rvalid is never earlier than the cycle after gnt.
- out_valid is 0 in every cycle not listed above.
- Byte enables and store lanes (addr[1:0]=a):
  - SB: be = 4'b0001<<a, wdata = {4{opr_b[7:0]}}
  - SH: be = 4'b0011<<a, wdata = {2{opr_b[15:0]}}
  - SW: be = 4'b1111, wdata = opr_b
  - Loads: be as for the same size; dmem_we=0.
- Load extraction:
  - LB/LBU: byte rdata[8a+7:8a], sign-/zero-extended.
  - LH/LHU: halfword rdata[8a+15:8a], sign-/zero-extended.
  - LW: rdata.
- dm_en=1 with a non-load/store lsuop: treated as dm_en=0.
- Reset mid-operation (REQ or RSP): state->IDLE at that edge; the request is dropped; a later rvalid is ignored.

Test Plan:
- ALU pass-through: in_valid, dm_en=0, rd=5, opr_res=0x1234, rf_en=1 -> next cycle out_valid=1, out_rd=5, out_opr_res=0x1234, out_ldata=0.
- SB, opr_res=0x1003, opr_b=0xAB, gnt held low 2 cycles -> dmem_req high 3 cycles with be=4'b1000, wdata=0xABABABAB, addr=0x1000 stable; out_valid 1 cycle after gnt; in_ready=0 throughout.
- LB, addr=0x2002, rdata=0x0080FF00, rvalid 2 cycles after gnt -> out_ldata=0xFFFFFF80. LBU with the same values -> 0x00000080.
- LH, addr=0x2002, rdata=0x8001_0000 -> out_ldata=0xFFFF8001. LW, addr=0x2001 -> no dmem_req, out_misaligned=1, out_rf_en=0.
- rst asserted while in RSP, then rvalid pulses -> no out_valid; state IDLE; in_ready=1 the cycle after reset.
- Back-to-back: LW then ADD presented continuously -> ADD held (in_ready=0) until the LW completes; exactly two out_valid pulses, in order.
